// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a 5-stage MIPS-style pipeline. Holds the PC,
// drives it to instruction memory, and registers the returned instruction
// into the IF/ID pipeline register. Also counts loaded instructions and
// inserted bubbles.
//
// Parameters
//   RESET_PC         PC value loaded on reset
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-low reset
//   Stall            hold PC and IF/ID (overridden by any redirect)
//   Flush            replace IF/ID contents with a bubble
//   BranchTaken      branch resolved taken in EX (highest priority)
//   BranchTarget     branch target address
//   JumpTaken        j/jal/jr decoded in ID
//   JumpTarget       jump target address
//   Address          current PC, to instruction memory
//   Instruction      combinational instruction-memory read data for Address
//   IFID_Instruction registered instruction
//   IFID_PC          registered PC of that instruction
//   IFID_PCPlus4     registered PC+4 (jal link value)
//   IFID_Valid       1 when IF/ID holds a real instruction
//   FetchCount       number of valid IF/ID loads (wraps)
//   BubbleCount      number of bubbles inserted (wraps)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
);

    // What the IF/ID register does this cycle.
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_e;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] redirect_target;
    logic        redirect;
    ifid_op_e    ifid_op;

    assign Address  = pc;
    assign pc_plus4 = pc + 32'd4;   // natural 32-bit wrap at the top of memory

    // Branch beats jump when both fire: the branch is older (in EX), so the
    // jump in ID is on the wrong path and gets squashed along with IF.
    assign redirect = BranchTaken | JumpTaken;

    always_comb begin
        redirect_target = JumpTarget;
        if (BranchTaken) begin
            redirect_target = BranchTarget;
        end
        // Instructions are word aligned; drop any stray low bits.
        redirect_target[1:0] = 2'b00;
    end

    // A redirect must win over Stall, otherwise the wrong-path instruction
    // would be held in IF/ID and the target fetch lost.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = redirect_target;
        end else if (Stall) begin
            pc_next = pc;
        end
    end

    always_comb begin
        ifid_op = IFID_LOAD;
        if (Flush || redirect) begin
            ifid_op = IFID_BUBBLE;
        end else if (Stall) begin
            ifid_op = IFID_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            IFID_Instruction <= 32'h0;
            IFID_PC          <= 32'h0;
            IFID_PCPlus4     <= 32'h0;
            IFID_Valid       <= 1'b0;
            FetchCount       <= 32'h0;
            BubbleCount      <= 32'h0;
        end else begin
            case (ifid_op)
                IFID_LOAD: begin
                    IFID_Instruction <= Instruction;
                    IFID_PC          <= pc;
                    IFID_PCPlus4     <= pc_plus4;
                    IFID_Valid       <= 1'b1;
                    FetchCount       <= FetchCount + 32'd1;
                end
                IFID_BUBBLE: begin
                    // All-zero word is sll $0,$0,0, i.e. a nop.
                    IFID_Instruction <= 32'h0;
                    IFID_PC          <= 32'h0;
                    IFID_PCPlus4     <= 32'h0;
                    IFID_Valid       <= 1'b0;
                    BubbleCount      <= BubbleCount + 32'd1;
                end
                default: begin
                    // hold: IF/ID and counters keep their values
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A behavioural model of the fetch stage
// is stepped on every rising edge from the same inputs; a compare process
// checks all outputs against it on every falling edge. Literal expectations
// after key directed steps pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpTaken;
    logic [31:0] JumpTarget;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;
    logic [31:0] BubbleCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .JumpTaken        (JumpTaken),
        .JumpTarget       (JumpTarget),
        .Address          (Address),
        .Instruction      (Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC          (IFID_PC),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .FetchCount       (FetchCount),
        .BubbleCount      (BubbleCount)
    );

    // Instruction memory: a content pattern unique per word address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign Instruction = imem(Address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_ok = 1'b0;
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_fetch, m_bubble;
    logic        m_valid;

    always @(posedge clk) begin
        logic [31:0] tgt;
        if (!reset) begin
            m_ok     = 1'b1;
            m_pc     = 32'h00400000;
            m_instr  = 0; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0;
            m_fetch  = 0; m_bubble = 0;
        end else if (m_ok) begin
            tgt = BranchTaken ? BranchTarget : JumpTarget;
            tgt = tgt & ~32'd3;
            if (Flush || BranchTaken || JumpTaken) begin
                m_instr = 0; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0;
                m_bubble = m_bubble + 1;
            end else if (!Stall) begin
                m_instr = imem(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_valid = 1;
                m_fetch = m_fetch + 1;
            end
            if (BranchTaken || JumpTaken) m_pc = tgt;
            else if (!Stall)              m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_Address",     Address,          m_pc);
            chk("m_IFID_Instr",  IFID_Instruction, m_instr);
            chk("m_IFID_PC",     IFID_PC,          m_ifpc);
            chk("m_IFID_PCP4",   IFID_PCPlus4,     m_ifpc4);
            chk("m_IFID_Valid",  {31'd0, IFID_Valid}, {31'd0, m_valid});
            chk("m_FetchCount",  FetchCount,       m_fetch);
            chk("m_BubbleCount", BubbleCount,      m_bubble);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic st, input logic fl,
                        input logic bt, input logic [31:0] btg,
                        input logic jt, input logic [31:0] jtg);
        reset = r; Stall = st; Flush = fl;
        BranchTaken = bt; BranchTarget = btg;
        JumpTaken = jt; JumpTarget = jtg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 0; Stall = 0; Flush = 0;
        BranchTaken = 0; BranchTarget = 0; JumpTaken = 0; JumpTarget = 0;

        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 32'h1234, 1, 32'h5678);
        chk("rst_addr",   Address, 32'h00400000);
        chk("rst_valid",  {31'd0, IFID_Valid}, 32'd0);
        chk("rst_fetch",  FetchCount, 0);
        chk("rst_bubble", BubbleCount, 0);

        // first cycle after release
        reset = 1;
        #1;
        chk("rel_addr",  Address, 32'h00400000);
        chk("rel_valid", {31'd0, IFID_Valid}, 32'd0);

        // sequential fetch
        idle();
        chk("seq1_addr", Address, 32'h00400004);
        chk("seq1_ifpc", IFID_PC, 32'h00400000);
        idle();
        idle();
        chk("seq3_addr",  Address, 32'h0040000C);
        chk("seq3_ifpc",  IFID_PC, 32'h00400008);
        chk("seq3_fetch", FetchCount, 3);
        idle();
        chk("seq4_addr", Address, 32'h00400010);

        // stall two cycles
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("stall_addr",   Address, 32'h00400010);
        chk("stall_ifpc",   IFID_PC, 32'h0040000C);
        chk("stall_fetch",  FetchCount, 4);
        chk("stall_bubble", BubbleCount, 0);
        idle();
        chk("unstall_addr", Address, 32'h00400014);

        // branch with misaligned target
        step(1, 0, 0, 1, 32'h0040001F, 0, 32'h0);
        chk("br_addr",   Address, 32'h0040001C);
        chk("br_valid",  {31'd0, IFID_Valid}, 32'd0);
        chk("br_instr",  IFID_Instruction, 32'h0);
        chk("br_bubble", BubbleCount, 1);
        idle();
        chk("br_next_ifpc", IFID_PC, 32'h0040001C);

        // branch + jump + stall: branch wins, one bubble
        step(1, 1, 0, 1, 32'h00400100, 1, 32'h00400200);
        chk("pri_addr",   Address, 32'h00400100);
        chk("pri_bubble", BubbleCount, 2);

        // flush alone advances; flush with stall holds PC
        step(1, 0, 1, 0, 0, 0, 0);
        chk("fl_addr",   Address, 32'h00400104);
        chk("fl_bubble", BubbleCount, 3);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("flst_addr",   Address, 32'h00400104);
        chk("flst_bubble", BubbleCount, 4);

        // jump to top of memory then wrap
        step(1, 0, 0, 0, 0, 1, 32'hFFFFFFFE);
        chk("jtop_addr", Address, 32'hFFFFFFFC);
        idle();
        chk("wrap_addr", Address, 32'h00000000);
        chk("wrap_ifpc", IFID_PC, 32'hFFFFFFFC);
        chk("wrap_p4",   IFID_PCPlus4, 32'h00000000);

        // jump overrides stall
        step(1, 1, 0, 0, 0, 1, 32'h00400300);
        chk("jst_addr", Address, 32'h00400300);

        // reset mid stall/redirect
        step(0, 1, 0, 0, 0, 1, 32'h00400400);
        chk("mrst_addr",   Address, 32'h00400000);
        chk("mrst_valid",  {31'd0, IFID_Valid}, 32'd0);
        chk("mrst_fetch",  FetchCount, 0);
        chk("mrst_bubble", BubbleCount, 0);

        // mixed control, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            step(1, ($urandom_range(3) == 0), ($urandom_range(5) == 0),
                 ($urandom_range(7) == 0), $urandom,
                 ($urandom_range(6) == 0), $urandom);
        end

        idle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
